// File: rtl/button_debounce.sv
// ============================================================================
// button_debounce: per-channel synchroniser + stability counter, with clean level and rise/fall strobes
// Rev 1.0
// ============================================================================
`default_nettype none

module button_debounce #(
  parameter int WIDTH           = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_rise,
  output logic [WIDTH-1:0] btn_fall
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CNT_W-1:0] cnt    [WIDTH];
  logic [WIDTH-1:0] sync;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
      btn_level <= '0;
      btn_rise  <= '0;
      btn_fall  <= '0;
    end else begin
      sync_q[0] <= btn_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      btn_rise <= '0;
      btn_fall <= '0;
      // Any agreement with the accepted level restarts the stability window.
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == btn_level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == C_CNT_LAST) begin
          cnt[i]       <= '0;
          btn_level[i] <= sync[i];
          btn_rise[i]  <= sync[i];
          btn_fall[i]  <= ~sync[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_button_debounce.sv
// ============================================================================
// tb_button_debounce: random and directed stimulus against a sliding-window reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_button_debounce;

  localparam int W    = 2;
  localparam int SYNC = 2;
  localparam int D    = 8;
  localparam int CW   = 4;
  localparam int MAXE = 4096;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] btn_in;
  logic [W-1:0] btn_level;
  logic [W-1:0] btn_rise;
  logic [W-1:0] btn_fall;

  int n_cmp;
  int n_err;

  // Reference model state: histories indexed by edge number
  logic [W-1:0] pin_h [MAXE];
  logic         rst_h [MAXE];
  logic [W-1:0] s_h   [MAXE];
  int           e;
  int           last_ev [W];
  logic [W-1:0] m_level;
  logic [W-1:0] m_rise;
  logic [W-1:0] m_fall;

  button_debounce #(
    .WIDTH          (W),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_in   (btn_in),
    .btn_level(btn_level),
    .btn_rise (btn_rise),
    .btn_fall (btn_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: edge %0d observed %0h expected %0h", tag, e, got, exp);
    end
  endtask

  // Level flips once the synchronised value has disagreed with it on D
  // consecutive edges, all inside the window since the last reset/flip.
  task automatic model_edge();
    logic [W-1:0] s;
    logic         ok;
    e++;
    if (e >= MAXE) begin
      $display("FAIL model_range: edge %0d exceeds history %0d", e, MAXE);
      $fatal(1);
    end
    pin_h[e] = btn_in;
    rst_h[e] = rst_n;
    if (e - SYNC < 1) begin
      s = '0;
    end else begin
      s = pin_h[e-SYNC];
      for (int k = e - SYNC; k < e; k++) begin
        if (!rst_h[k]) s = '0;
      end
    end
    s_h[e] = s;
    m_rise = '0;
    m_fall = '0;
    if (!rst_n) begin
      m_level = '0;
      for (int ch = 0; ch < W; ch++) last_ev[ch] = e;
    end else begin
      for (int ch = 0; ch < W; ch++) begin
        if (e - last_ev[ch] >= D) begin
          ok = 1'b1;
          for (int k = e - D + 1; k <= e; k++) begin
            if (s_h[k][ch] == m_level[ch]) ok = 1'b0;
          end
          if (ok) begin
            m_level[ch] = ~m_level[ch];
            m_rise[ch]  = m_level[ch];
            m_fall[ch]  = ~m_level[ch];
            last_ev[ch] = e;
          end
        end
      end
    end
  endtask

  // Called at a negedge: drive, clock once, compare at the following negedge.
  task automatic step(input logic [W-1:0] din, input logic rst_val);
    btn_in = din;
    rst_n  = rst_val;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_val("level", 32'(btn_level), 32'(m_level));
    check_val("rise",  32'(btn_rise),  32'(m_rise));
    check_val("fall",  32'(btn_fall),  32'(m_fall));
  endtask

  int           press_lat;
  int           rise1_cnt;
  int           fall1_cnt;
  int           hold [W];
  logic [W-1:0] rnd_in;

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    e       = 0;
    m_level = '0;
    m_rise  = '0;
    m_fall  = '0;
    for (int ch = 0; ch < W; ch++) last_ev[ch] = 0;
    btn_in  = '0;
    rst_n   = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3; i++) step(2'b00, 1'b0);
    check_val("reset_level", 32'(btn_level), 32'd0);
    step(2'b00, 1'b1);

    // Clean press: level must appear on the 10th edge after the pin changes
    press_lat = -1;
    for (int i = 1; i <= 20; i++) begin
      step(2'b01, 1'b1);
      if (btn_level[0] && press_lat < 0) press_lat = i;
    end
    check_val("press_latency", 32'(press_lat), 32'd10);

    for (int i = 0; i < 20; i++) step(2'b00, 1'b1);

    // Short glitch: 7 cycles high must be rejected
    for (int i = 0; i < 7; i++)  step(2'b01, 1'b1);
    for (int i = 0; i < 30; i++) step(2'b00, 1'b1);
    check_val("glitch_level", 32'(btn_level), 32'd0);

    // Bounce on channel 1, then hold high
    rise1_cnt = 0;
    fall1_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step({((i / 3) % 2 == 0), 1'b0}, 1'b1);
      rise1_cnt += int'(btn_rise[1]);
      fall1_cnt += int'(btn_fall[1]);
    end
    for (int i = 0; i < 20; i++) begin
      step(2'b10, 1'b1);
      rise1_cnt += int'(btn_rise[1]);
      fall1_cnt += int'(btn_fall[1]);
    end
    check_val("bounce_rises", 32'(rise1_cnt), 32'd1);
    check_val("bounce_falls", 32'(fall1_cnt), 32'd0);

    // Release from 2'b11 on both channels at once
    for (int i = 0; i < 15; i++) step(2'b11, 1'b1);
    check_val("both_high", 32'(btn_level), 32'd3);
    for (int i = 0; i < 15; i++) step(2'b00, 1'b1);
    check_val("both_low", 32'(btn_level), 32'd0);

    // Reset mid-count
    for (int i = 0; i < 5; i++) step(2'b01, 1'b1);
    step(2'b01, 1'b0);
    check_val("midreset_out", 32'({btn_level, btn_rise, btn_fall}), 32'd0);
    for (int i = 0; i < 20; i++) step(2'b01, 1'b1);

    // Steady state: counters must idle at zero
    for (int i = 0; i < 20; i++) step(2'b10, 1'b1);
    for (int i = 0; i < 100; i++) begin
      step(2'b10, 1'b1);
      check_val("steady_cnt0", 32'(dut.cnt[0]), 32'd0);
      check_val("steady_cnt1", 32'(dut.cnt[1]), 32'd0);
    end

    // Random hold lengths straddling D, with occasional resets
    rnd_in = 2'b00;
    for (int ch = 0; ch < W; ch++) hold[ch] = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int ch = 0; ch < W; ch++) begin
        if (hold[ch] == 0) begin
          rnd_in[ch] = 1'($urandom_range(0, 1));
          hold[ch]   = int'($urandom_range(1, 14));
        end
        hold[ch]--;
      end
      step(rnd_in, ($urandom_range(0, 299) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
